regfile_sb: RTL and testbench

//  Parametrised multi-port integer register file with write-port bypass and a per-register

---
 rtl/regfile_sb_pkg.sv | 11 +
 rtl/regfile_sb_scoreboard.sv | 85 ++++++++
 rtl/regfile_sb.sv | 82 ++++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int RF_XLEN     = 32;
  localparam int RF_NREG     = 32;
  localparam int RF_NR       = 2;
  localparam int RF_NW       = 1;
  localparam int RF_MAXPEND  = 3;
  localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one saturating-at-zero counter per architectural register,
// same-cycle retire visibility for issue_ready / rd_busy, and a sticky underflow flag.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREG    = RF_NREG,
  parameter int NR      = RF_NR,
  parameter int NW      = RF_NW,
  parameter int MAXPEND = RF_MAXPEND,
  localparam int AW     = $clog2(NREG),
  localparam int PW     = $clog2(MAXPEND + 1),
  localparam int CW     = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR-1:0]    rd_busy,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             issue_ready,
  input  logic [NW-1:0]    wb_retire,
  input  logic [NW*AW-1:0] wb_addr,
  input  logic             flush,
  output logic             err_underflow
);

  localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

  logic [PW-1:0] pend     [NREG];
  logic [PW-1:0] pend_nxt [NREG];
  logic [CW-1:0] ret      [NREG];
  logic [CW-1:0] remain   [NREG];
  logic          issue_fire;
  logic          uflow;

  // Count retires per register and what is left outstanding after them (never below zero).
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      ret[r] = '0;
      for (int j = 0; j < NW; j++) begin
        if (wb_retire[j] && wb_addr[j*AW +: AW] == AW'(r)) ret[r] = ret[r] + CW'(1);
      end
      remain[r] = (CW'(pend[r]) > ret[r]) ? CW'(pend[r]) - ret[r] : '0;
    end
  end

  assign issue_ready = rst || (issue_rd == ZERO) || (remain[issue_rd] < CW'(MAXPEND));
  assign issue_fire  = !rst && issue_valid && issue_ready && (issue_rd != ZERO);

  // Next counter values; flush wins over issue and retire, x0 never tracks anything.
  always_comb begin
    uflow = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      logic [CW-1:0] total;
      total = CW'(pend[r]) + ((issue_fire && issue_rd == AW'(r)) ? CW'(1) : CW'(0));
      if (r == 0 || flush) begin
        pend_nxt[r] = '0;
      end else if (ret[r] > total) begin
        pend_nxt[r] = '0;
        uflow       = 1'b1;
      end else begin
        pend_nxt[r] = PW'(total - ret[r]);
      end
    end
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) pend[r] <= pend_nxt[r];
      if (uflow) err_underflow <= 1'b1;
    end
  end

  // Busy lookup per read port; remain[0] is always zero so x0 is never busy.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_busy[i] = !rst && (remain[rd_addr[i*AW +: AW]] != '0);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with writeback bypass and pending-write scoreboard.
// x0 reads as zero and ignores writes; later write ports win on address collisions.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN    = RF_XLEN,
  parameter int NREG    = RF_NREG,
  parameter int NR      = RF_NR,
  parameter int NW      = RF_NW,
  parameter int MAXPEND = RF_MAXPEND,
  localparam int AW     = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  output logic               issue_ready,
  input  logic [NW-1:0]      wb_we,
  input  logic [NW-1:0]      wb_retire,
  input  logic [NW*AW-1:0]   wb_addr,
  input  logic [NW*XLEN-1:0] wb_data,
  input  logic               flush,
  output logic               err_underflow
);

  localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

  logic [XLEN-1:0] regs [NREG];

  // Storage; ascending port loop makes the highest port's write the one that lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wb_we[j] && wb_addr[j*AW +: AW] != ZERO)
          regs[wb_addr[j*AW +: AW]] <= wb_data[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rd_addr[i*AW +: AW];

    // Read mux: storage, overridden by the highest matching write port, forced to 0 for x0/reset.
    always_comb begin
      data = regs[addr];
      for (int j = 0; j < NW; j++) begin
        if (wb_we[j] && wb_addr[j*AW +: AW] == addr) data = wb_data[j*XLEN +: XLEN];
      end
      if (rst || addr == ZERO) data = '0;
    end

    assign rd_data[i*XLEN +: XLEN] = data;
  end

  regfile_sb_scoreboard #(
    .NREG    (NREG),
    .NR      (NR),
    .NW      (NW),
    .MAXPEND (MAXPEND)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .rd_addr       (rd_addr),
    .rd_busy       (rd_busy),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .wb_retire     (wb_retire),
    .wb_addr       (wb_addr),
    .flush         (flush),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (NR=2, NW=2) with an integer-level reference model
// compared on every falling edge, plus literal expectations at key points.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int MAXPEND = 3;
  localparam int AW = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*XLEN-1:0] rd_data;
  logic [NR-1:0]      rd_busy;
  logic               issue_valid;
  logic [AW-1:0]      issue_rd;
  logic               issue_ready;
  logic [NW-1:0]      wb_we;
  logic [NW-1:0]      wb_retire;
  logic [NW*AW-1:0]   wb_addr;
  logic [NW*XLEN-1:0] wb_data;
  logic               flush;
  logic               err_underflow;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_regs [NREG];
  int          m_pend [NREG];
  logic        m_err = 1'b0;

  regfile_sb #(
    .XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW), .MAXPEND(MAXPEND)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_we(wb_we), .wb_retire(wb_retire), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int ret_cnt(input int r);
    int n = 0;
    for (int j = 0; j < NW; j++)
      if (wb_retire[j] && int'(wb_addr[j*AW +: AW]) == r) n++;
    return n;
  endfunction

  function automatic int remain(input int r);
    int v;
    if (r == 0) return 0;
    v = m_pend[r] - ret_cnt(r);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic logic exp_ready();
    if (rst || issue_rd == 0) return 1'b1;
    return remain(int'(issue_rd)) < MAXPEND;
  endfunction

  function automatic logic [31:0] exp_data(input int a);
    logic [31:0] v;
    if (rst || a == 0) return 32'h0;
    v = m_regs[a];
    for (int j = 0; j < NW; j++)
      if (wb_we[j] && int'(wb_addr[j*AW +: AW]) == a) v = wb_data[j*XLEN +: XLEN];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = 32'h0;
        m_pend[r] = 0;
      end
      m_err = 1'b0;
    end else begin
      logic fire;
      fire = issue_valid && exp_ready() && issue_rd != 0;
      for (int j = 0; j < NW; j++)
        if (wb_we[j] && wb_addr[j*AW +: AW] != 0) m_regs[wb_addr[j*AW +: AW]] = wb_data[j*XLEN +: XLEN];
      for (int r = 1; r < NREG; r++) begin
        int v;
        if (flush) v = 0;
        else begin
          v = m_pend[r] + ((fire && int'(issue_rd) == r) ? 1 : 0) - ret_cnt(r);
          if (v < 0) begin
            v = 0;
            m_err = 1'b1;
          end
        end
        m_pend[r] = v;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      check($sformatf("cyc_rd_data%0d", i), rd_data[i*XLEN +: XLEN], exp_data(int'(rd_addr[i*AW +: AW])));
      check($sformatf("cyc_rd_busy%0d", i), {31'b0, rd_busy[i]},
            {31'b0, !rst && remain(int'(rd_addr[i*AW +: AW])) > 0});
    end
    check("cyc_issue_ready", {31'b0, issue_ready}, {31'b0, exp_ready()});
    check("cyc_err_underflow", {31'b0, err_underflow}, {31'b0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rd_addr = '0; issue_valid = 1'b0; issue_rd = '0; wb_we = '0; wb_retire = '0;
    wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [AW-1:0] r);
    step();
    issue_valid = 1'b1;
    issue_rd = r;
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    issue_rd = 5'd3;
    #1;
    check("rst_rd_data", rd_data[31:0], 32'h0);
    check("rst_rd_busy", {30'b0, rd_busy}, 32'h0);
    check("rst_issue_ready", {31'b0, issue_ready}, 32'h1);
    check("rst_err", {31'b0, err_underflow}, 32'h0);
    step();
    step();
    rst = 1'b0;

    // 1: bypass then storage
    step();
    wb_we = 2'b01; wb_addr[4:0] = 5'd5; wb_data[31:0] = 32'hDEADBEEF; rd_addr[4:0] = 5'd5;
    #1 check("t1_bypass", rd_data[31:0], 32'hDEADBEEF);
    step();
    rd_addr[4:0] = 5'd5;
    #1 check("t1_storage", rd_data[31:0], 32'hDEADBEEF);

    // 2: two-port collision, x0 write ignored
    step();
    wb_we = 2'b11; wb_addr = {5'd7, 5'd7}; wb_data = {32'h22, 32'h11}; rd_addr = {5'd7, 5'd0};
    #1 check("t2_bypass_hi_port", rd_data[63:32], 32'h22);
    step();
    wb_we = 2'b01; wb_addr[4:0] = 5'd0; wb_data[31:0] = 32'hFFFF; rd_addr = {5'd0, 5'd7};
    #1;
    check("t2_x7_stored", rd_data[31:0], 32'h22);
    check("t2_x0_zero", rd_data[63:32], 32'h0);
    check("t2_x0_busy", {31'b0, rd_busy[1]}, 32'h0);

    // 3: MAXPEND limit, retire+issue same cycle
    for (int k = 0; k < 3; k++) begin
      issue(5'd3);
      #1 check($sformatf("t3_ready_%0d", k), {31'b0, issue_ready}, 32'h1);
    end
    issue(5'd3);
    #1 check("t3_full", {31'b0, issue_ready}, 32'h0);
    issue(5'd3);
    wb_retire = 2'b01; wb_addr[4:0] = 5'd3; rd_addr[4:0] = 5'd3;
    #1;
    check("t3_retire_ready", {31'b0, issue_ready}, 32'h1);
    check("t3_retire_busy", {31'b0, rd_busy[0]}, 32'h1);
    step();
    issue_rd = 5'd3; rd_addr[4:0] = 5'd3;
    #1;
    check("t3_still_full", {31'b0, issue_ready}, 32'h0);
    check("t3_model_pend3", m_pend[3], 32'd3);

    // 4: retire with write pairs busy-clear with bypass
    issue(5'd9);
    rd_addr[4:0] = 5'd9;
    step();
    wb_we = 2'b01; wb_retire = 2'b01; wb_addr[4:0] = 5'd9; wb_data[31:0] = 32'h42; rd_addr = {5'd9, 5'd9};
    #1;
    check("t4_model_pend9", m_pend[9], 32'd1);
    check("t4_busy_clear", {30'b0, rd_busy}, 32'h0);
    check("t4_bypass", rd_data[31:0], 32'h42);
    step();
    rd_addr[4:0] = 5'd9;
    #1;
    check("t4_after_busy", {31'b0, rd_busy[0]}, 32'h0);
    check("t4_after_data", rd_data[31:0], 32'h42);
    check("t4_model_pend9_0", m_pend[9], 32'd0);

    // 5: flush overrides issue, then underflow is sticky
    issue(5'd4);
    issue(5'd4);
    issue(5'd6);
    step();
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4; rd_addr = {5'd6, 5'd4};
    #1;
    check("t5_flush_ready", {31'b0, issue_ready}, 32'h1);
    check("t5_busy_before", {30'b0, rd_busy}, 32'h3);
    step();
    rd_addr = {5'd6, 5'd4}; issue_rd = 5'd3;
    #1;
    check("t5_busy_after", {30'b0, rd_busy}, 32'h0);
    check("t5_x3_ready", {31'b0, issue_ready}, 32'h1);
    check("t5_model_pend4", m_pend[4], 32'd0);
    step();
    wb_retire = 2'b01; wb_addr[4:0] = 5'd4;
    #1 check("t5_err_pre", {31'b0, err_underflow}, 32'h0);
    step();
    #1 check("t5_err_set", {31'b0, err_underflow}, 32'h1);
    step();
    #1 check("t5_err_sticky", {31'b0, err_underflow}, 32'h1);

    // 6: asynchronous reset between edges
    issue(5'd10);
    issue(5'd10);
    step();
    rd_addr = {5'd11, 5'd10}; wb_we = 2'b01; wb_addr[4:0] = 5'd11; wb_data[31:0] = 32'h55; issue_rd = 5'd10;
    #1;
    check("t6_busy_pre", {30'b0, rd_busy}, 32'h1);
    check("t6_bypass_pre", rd_data[63:32], 32'h55);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_data", rd_data[63:32], 32'h0);
    check("t6_rst_busy", {30'b0, rd_busy}, 32'h0);
    check("t6_rst_err", {31'b0, err_underflow}, 32'h0);
    check("t6_rst_ready", {31'b0, issue_ready}, 32'h1);
    step();
    rst = 1'b0;
    rd_addr = {5'd10, 5'd5};
    #1;
    check("t6_regs_cleared", rd_data[31:0], 32'h0);
    check("t6_pend_cleared", {30'b0, rd_busy}, 32'h0);
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
